// File: rtl/right_shift_pipe_pkg.sv
// Shared sizing helpers and the per-stage record for the log right-shift pipeline.
// Build option RIGHT_SHIFT_PIPE_ARITH_EN makes the arith flag in the record live; otherwise it is tied to zero.
package right_shift_pipe_pkg;

    localparam int MAX_WIDTH = 64;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // One stage per shift bit; width 2 still needs a single stage.
    function automatic int stages_of(input int width);
        return (width < 2) ? 1 : clog2(width);
    endfunction

    localparam int MAX_STAGES = clog2(MAX_WIDTH);

    // Sized for the widest supported build; narrower builds use the low bits and leave the rest zero.
    typedef struct packed {
        logic [MAX_WIDTH-1:0]  data;
        logic [MAX_STAGES-1:0] shift;
        logic                  arith;
        logic                  vld;
    } stage_rec_t;

endpackage

// File: rtl/right_shift_pipe_if.sv
// Producer/consumer bundle for right_shift_pipe; slave modport is the pipeline side.
// RIGHT_SHIFT_PIPE_ARITH_EN adds the arith qualifier travelling with iBits.
interface right_shift_pipe_if
    import right_shift_pipe_pkg::*;
#(
    parameter int width = 8
);
    localparam int STAGES = stages_of(width);

    logic [width-1:0]  iBits;
    logic [STAGES-1:0] shift;
    logic              iValid;
    logic              iReady;
    logic [width-1:0]  oBits;
    logic              oValid;
    logic              oReady;
`ifdef RIGHT_SHIFT_PIPE_ARITH_EN
    logic              arith;

    modport master (
        output iBits, shift, iValid, arith, oReady,
        input  iReady, oBits, oValid
    );

    modport slave (
        input  iBits, shift, iValid, arith, oReady,
        output iReady, oBits, oValid
    );
`else
    modport master (
        output iBits, shift, iValid, oReady,
        input  iReady, oBits, oValid
    );

    modport slave (
        input  iBits, shift, iValid, oReady,
        output iReady, oBits, oValid
    );
`endif

endinterface

// File: rtl/right_shift_stage.sv
// One registered stage of the log shifter: shifts by 2^k when shift bit k is set, 1 cycle.
// Loads when empty or when its content leaves this cycle; otherwise holds data and valid.
module right_shift_stage
    import right_shift_pipe_pkg::*;
#(
    parameter int width = 8,
    parameter int k     = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  stage_rec_t in_rec,
    output logic       in_rdy,
    output stage_rec_t out_rec,
    input  logic       out_rdy
);
    localparam int AMT = 1 << k;

    stage_rec_t       rec_q;
    stage_rec_t       rec_d;
    logic             load;
    logic             fill;
    logic [width-1:0] cur;
    logic [width-1:0] shifted;

    always_comb begin
        load    = !rec_q.vld || out_rdy;
        cur     = in_rec.data[width-1:0];
        // Sign is still in the MSB after earlier arithmetic stages, so it is safe to re-read here.
        fill    = in_rec.arith & cur[width-1];
        shifted = cur;
        if (in_rec.shift[k]) begin
            shifted = {{AMT{fill}}, cur[width-1:AMT]};
        end
    end

    // Data only moves with a valid item, so bubbles never disturb the output word.
    always_comb begin
        rec_d = rec_q;
        if (load) begin
            rec_d.vld = in_rec.vld;
            if (in_rec.vld) begin
                rec_d.data             = '0;
                rec_d.data[width-1:0]  = shifted;
                rec_d.shift            = in_rec.shift;
                rec_d.arith            = in_rec.arith;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rec_q <= '0;
        end else begin
            rec_q <= rec_d;
        end
    end

    assign in_rdy  = load;
    assign out_rec = rec_q;

endmodule

// File: rtl/right_shift_pipe.sv
// Pipelined logical (optionally arithmetic via RIGHT_SHIFT_PIPE_ARITH_EN) right shifter, latency clog2(width).
// Valid/ready on both sides; stalls propagate back stage by stage and bubbles are squeezed out.
module right_shift_pipe
    import right_shift_pipe_pkg::*;
#(
    parameter int width = 8
) (
    input  logic               clk,
    input  logic               rst,
    right_shift_pipe_if.slave  bus
);
    localparam int STAGES = stages_of(width);

    if (width < 2) begin : g_width_too_small
        $error("right_shift_pipe: width must be at least 2");
    end
    if (width > MAX_WIDTH) begin : g_width_too_large
        $error("right_shift_pipe: width exceeds MAX_WIDTH of right_shift_pipe_pkg");
    end

    stage_rec_t in_rec;
    stage_rec_t out_rec   [STAGES];
    logic       stage_rdy [STAGES];

    always_comb begin
        in_rec                    = '0;
        in_rec.data[width-1:0]    = bus.iBits;
        in_rec.shift[STAGES-1:0]  = bus.shift;
        in_rec.vld                = bus.iValid;
`ifdef RIGHT_SHIFT_PIPE_ARITH_EN
        in_rec.arith              = bus.arith;
`endif
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        stage_rec_t stage_in;
        logic       down_rdy;

        if (g == 0) begin : g_first
            assign stage_in = in_rec;
        end else begin : g_chain
            assign stage_in = out_rec[g-1];
        end

        if (g == STAGES - 1) begin : g_last
            assign down_rdy = bus.oReady;
        end else begin : g_mid
            assign down_rdy = stage_rdy[g+1];
        end

        right_shift_stage #(
            .width (width),
            .k     (g)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .in_rec  (stage_in),
            .in_rdy  (stage_rdy[g]),
            .out_rec (out_rec[g]),
            .out_rdy (down_rdy)
        );
    end

    assign bus.iReady = stage_rdy[0];
    assign bus.oBits  = out_rec[STAGES-1].data[width-1:0];
    assign bus.oValid = out_rec[STAGES-1].vld;

endmodule

// File: tb/tb_right_shift_pipe.sv
// Scoreboard bench for right_shift_pipe (width 8): directed cases then 10k random transfers with random oReady.
module tb_right_shift_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    right_shift_pipe_if #(.width(8)) bus ();

    right_shift_pipe #(.width(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] exp;
        int         cyc;
        bit         chk_lat;
    } sb_t;

    sb_t sb_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    bit  mon_en = 1'b0;

    function automatic logic [7:0] ref_shift(input logic [7:0] b, input int sh, input bit ar);
        logic signed [7:0] sb;
        sb = b;
        if (ar) return sb >>> sh;
        return b >> sh;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic drive(input bit v, input logic [7:0] b, input logic [2:0] sh, input bit ar,
                         input bit ordy, input bit chk, output bit acc);
        bit ar_eff;
        @(negedge clk);
        bus.iValid = v;
        bus.iBits  = b;
        bus.shift  = sh;
        bus.oReady = ordy;
`ifdef RIGHT_SHIFT_PIPE_ARITH_EN
        bus.arith  = ar;
        ar_eff     = ar;
`else
        ar_eff     = 1'b0 & ar;
`endif
        #1;
        acc = v && (bus.iReady === 1'b1);
        if (acc) sb_q.push_back('{ref_shift(b, int'(sh), ar_eff), cyc, chk});
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, acc);
    endtask

    // Output monitor: pops the scoreboard on every output transfer and checks stall stability.
    bit         prev_stall = 1'b0;
    bit         seen_out   = 1'b0;
    logic [7:0] prev_bits  = '0;

    always @(negedge clk) begin
        sb_t e;
        #2;
        if (mon_en && !rst) begin
            if (prev_stall) begin
                check("hold_ovalid", 32'(bus.oValid), 32'd1);
                check("hold_obits", 32'(bus.oBits), 32'(prev_bits));
            end
            if (!seen_out && bus.oValid !== 1'b1) check("idle_obits_zero", 32'(bus.oBits), 32'd0);
            if (bus.oValid === 1'b1) seen_out = 1'b1;
            if (bus.oValid === 1'b1 && bus.oReady === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("spurious_output", 32'(bus.oBits), 32'hDEAD_BEEF);
                end else begin
                    e = sb_q.pop_front();
                    check("data", 32'(bus.oBits), 32'(e.exp));
                    if (e.chk_lat) check("latency", 32'(cyc - e.cyc), 32'd3);
                end
            end
            prev_stall = (bus.oValid === 1'b1) && (bus.oReady !== 1'b1);
            prev_bits  = bus.oBits;
        end else begin
            prev_stall = 1'b0;
            seen_out   = 1'b0;
        end
    end

    initial begin
        bit         acc;
        bit         pend;
        int         got;
        int         n_acc;
        int         budget;
        logic [7:0] b;
        logic [2:0] sh;
        bit         ar;
        bit         v;
        bit         ordy;

        // Inputs offered during reset must not be captured.
        bus.iValid = 1'b1;
        bus.iBits  = 8'hAA;
        bus.shift  = 3'd1;
        bus.oReady = 1'b1;
`ifdef RIGHT_SHIFT_PIPE_ARITH_EN
        bus.arith  = 1'b0;
`endif
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst        = 1'b0;
        bus.iValid = 1'b0;
        #1;
        check("reset_ovalid", 32'(bus.oValid), 32'd0);
        check("reset_obits", 32'(bus.oBits), 32'd0);
        check("reset_iready", 32'(bus.iReady), 32'd1);
        mon_en = 1'b1;
        idle(5);

        // Streaming with oReady high: 0x2D, 0x01, 0x81 three cycles after each input.
        drive(1'b1, 8'hB4, 3'd2, 1'b0, 1'b1, 1'b1, acc); check("stream_accept0", 32'(acc), 32'd1);
        drive(1'b1, 8'hFF, 3'd7, 1'b0, 1'b1, 1'b1, acc); check("stream_accept1", 32'(acc), 32'd1);
        drive(1'b1, 8'h81, 3'd0, 1'b0, 1'b1, 1'b1, acc); check("stream_accept2", 32'(acc), 32'd1);
        idle(6);

        // Six stalled cycles: exactly three items fit, then iReady must be low.
        got  = 0;
        pend = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (!pend) begin
                b    = 8'($urandom);
                sh   = 3'($urandom);
                pend = 1'b1;
            end
            drive(1'b1, b, sh, 1'b0, 1'b0, 1'b0, acc);
            if (acc) begin
                got++;
                pend = 1'b0;
            end
        end
        check("stall_accepts", 32'(got), 32'd3);
        check("stall_iready", 32'(bus.iReady), 32'd0);
        budget = 0;
        while (pend && budget < 20) begin
            drive(1'b1, b, sh, 1'b0, 1'b1, 1'b0, acc);
            if (acc) pend = 1'b0;
            budget++;
        end
        check("stall_release", 32'(pend), 32'd0);
        idle(8);

        // Reset with two items in flight: neither may appear, and the next item takes 3 cycles.
        drive(1'b1, 8'h5A, 3'd1, 1'b0, 1'b1, 1'b0, acc);
        drive(1'b1, 8'hC3, 3'd4, 1'b0, 1'b1, 1'b0, acc);
        @(negedge clk);
        rst        = 1'b1;
        bus.iValid = 1'b0;
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idle(1);
            check("flush_ovalid", 32'(bus.oValid), 32'd0);
        end
        drive(1'b1, 8'h9C, 3'd3, 1'b0, 1'b1, 1'b1, acc);
        idle(6);

`ifdef RIGHT_SHIFT_PIPE_ARITH_EN
        drive(1'b1, 8'h90, 3'd3, 1'b1, 1'b1, 1'b1, acc);
        drive(1'b1, 8'h90, 3'd3, 1'b0, 1'b1, 1'b1, acc);
        drive(1'b1, 8'h80, 3'd7, 1'b1, 1'b1, 1'b1, acc);
        idle(6);
`endif

        // Random traffic with random backpressure; unaccepted inputs are held until taken.
        n_acc  = 0;
        budget = 0;
        pend   = 1'b0;
        while (n_acc < 10000 && budget < 60000) begin
            v    = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 7);
            if (!pend) begin
                b  = 8'($urandom);
                sh = 3'($urandom);
                ar = 1'($urandom);
            end
            drive(v, b, sh, ar, ordy, 1'b0, acc);
            pend = v && !acc;
            if (acc) n_acc++;
            budget++;
        end
        check("random_transfers", 32'(n_acc), 32'd10000);

        budget = 0;
        while (sb_q.size() != 0 && budget < 50) begin
            idle(1);
            budget++;
        end
        idle(2);
        check("drain_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
